// File: rtl/csa_tree_mult_pipe_if.sv
// Purpose: operand/result handshake bundle for the pipelined CSA-tree multiplier.
// Ports: master drives in_valid/in_a/in_b/in_signed/in_tag and out_ready;
//        slave drives in_ready and out_valid/out_product/out_tag.
interface csa_tree_mult_pipe_if #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 6
);
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     in_a;
  logic [WIDTH-1:0]     in_b;
  logic                 in_signed;
  logic [TAG_W-1:0]     in_tag;
  logic                 out_valid;
  logic                 out_ready;
  logic [2*WIDTH-1:0]   out_product;
  logic [TAG_W-1:0]     out_tag;

  modport master (
    output in_valid, in_a, in_b, in_signed, in_tag, out_ready,
    input  in_ready, out_valid, out_product, out_tag
  );

  modport slave (
    input  in_valid, in_a, in_b, in_signed, in_tag, out_ready,
    output in_ready, out_valid, out_product, out_tag
  );
endinterface

// File: rtl/csa_tree_mult_pipe.sv
// Purpose: WIDTH x WIDTH signed/unsigned multiplier, 3:2 carry-save tree + final CPA, tag passthrough.
// Latency: 4 cycles accept-to-out_valid, one op per cycle; flush kills all in-flight ops.
// Backpressure: in_ready = !(out_valid && !out_ready); a stall freezes every stage.
// Ports: clk, reset (sync, active-high), flush, bus (slave side of csa_tree_mult_pipe_if).
module csa_tree_mult_pipe #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 6
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  csa_tree_mult_pipe_if.slave   bus
);

  // Row count after k levels of 3:2 reduction starting from n rows.
  function automatic int rows_after(int n, int k);
    int r;
    r = n;
    for (int i = 0; i < k; i++) begin
      if (r > 2) r = 2 * (r / 3) + (r % 3);
    end
    return r;
  endfunction

  function automatic int num_levels(int n);
    int r;
    int l;
    r = n;
    l = 0;
    while (r > 2) begin
      r = 2 * (r / 3) + (r % 3);
      l++;
    end
    return l;
  endfunction

  localparam int P  = 2 * WIDTH;
  localparam int NR = WIDTH + 1;
  localparam int L  = num_levels(NR);
  localparam int L1 = (L + 1) / 2;
  localparam int R1 = rows_after(NR, L1);

  typedef logic [P-1:0] row_t;

  // Global stall: every stage holds while the output is blocked.
  logic w_adv;
  assign w_adv        = !(bus.out_valid && !bus.out_ready);
  assign bus.in_ready = w_adv;

  // Operand extension to WIDTH+1 bits; signed mode makes the extended MSB carry negative weight.
  logic [WIDTH:0] w_a_ext, w_b_ext, w_na_ext;
  assign w_a_ext  = {bus.in_signed & bus.in_a[WIDTH-1], bus.in_a};
  assign w_b_ext  = {bus.in_signed & bus.in_b[WIDTH-1], bus.in_b};
  assign w_na_ext = -w_a_ext;

  logic r_s1_vld, r_s2_vld, r_s3_vld, r_out_vld;
  logic [TAG_W-1:0] r_s1_tag, r_s2_tag, r_s3_tag, r_out_tag;
  logic [WIDTH:0]   r_s1_a, r_s1_na, r_s1_b;
  row_t r_s2_row [R1];
  row_t r_s3_row [2];
  row_t w_s2_row [R1];
  row_t w_s3_row [2];
  row_t w_pp     [NR];
  logic [P-1:0] r_prod;

  // Partial products, each sign-extended to the full product width. The top
  // multiplier bit has weight -2^WIDTH, so its row uses -a (registered in S1).
  for (genvar i = 0; i < WIDTH; i++) begin : g_pp
    assign w_pp[i] = r_s1_b[i] ? (row_t'({{(WIDTH-1){r_s1_a[WIDTH]}}, r_s1_a}) << i) : '0;
  end
  assign w_pp[WIDTH] = r_s1_b[WIDTH] ? (row_t'({{(WIDTH-1){r_s1_na[WIDTH]}}, r_s1_na}) << WIDTH) : '0;

  // Carry-save tree; levels 0..L1-1 feed the S2 register, L1..L-1 feed S3.
  for (genvar l = 0; l < L; l++) begin : g_lvl
    localparam int N = rows_after(NR, l);
    localparam int G = N / 3;
    localparam int M = N % 3;
    row_t w_src [N];
    row_t w_row [2*G+M];

    if (l == 0) begin : g_src_pp
      assign w_src = w_pp;
    end else if (l == L1) begin : g_src_reg
      assign w_src = r_s2_row;
    end else begin : g_src_prev
      assign w_src = g_lvl[l-1].w_row;
    end

    for (genvar g = 0; g < G; g++) begin : g_csa
      assign w_row[2*g]   = w_src[3*g] ^ w_src[3*g+1] ^ w_src[3*g+2];
      assign w_row[2*g+1] = {(w_src[3*g][P-2:0]   & w_src[3*g+1][P-2:0]) |
                             (w_src[3*g][P-2:0]   & w_src[3*g+2][P-2:0]) |
                             (w_src[3*g+1][P-2:0] & w_src[3*g+2][P-2:0]), 1'b0};
    end

    for (genvar r = 0; r < M; r++) begin : g_pass
      assign w_row[2*G+r] = w_src[3*G+r];
    end

    if (l == L1 - 1) begin : g_tap_s2
      assign w_s2_row = w_row;
    end
    if (l == L - 1) begin : g_tap_s3
      assign w_s3_row = w_row;
    end
  end

  // Valid bits: reset beats flush, flush beats stall.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      r_s1_vld  <= 1'b0;
      r_s2_vld  <= 1'b0;
      r_s3_vld  <= 1'b0;
      r_out_vld <= 1'b0;
    end else if (w_adv) begin
      r_s1_vld  <= bus.in_valid;
      r_s2_vld  <= r_s1_vld;
      r_s3_vld  <= r_s2_vld;
      r_out_vld <= r_s3_vld;
    end
  end

  // Datapath and tags: no reset. Operands load only with in_valid so idle bus values stay out.
  always_ff @(posedge clk) begin
    if (w_adv) begin
      if (bus.in_valid) begin
        r_s1_a   <= w_a_ext;
        r_s1_na  <= w_na_ext;
        r_s1_b   <= w_b_ext;
        r_s1_tag <= bus.in_tag;
      end
      r_s2_row <= w_s2_row;
      r_s2_tag <= r_s1_tag;
      r_s3_row <= w_s3_row;
      r_s3_tag <= r_s2_tag;
    end
  end

  // Output register only updates for a valid op so bubbles leave the result untouched.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_prod    <= '0;
      r_out_tag <= '0;
    end else if (w_adv && r_s3_vld && !flush) begin
      r_prod    <= r_s3_row[0] + r_s3_row[1];
      r_out_tag <= r_s3_tag;
    end
  end

  assign bus.out_valid   = r_out_vld;
  assign bus.out_product = r_prod;
  assign bus.out_tag     = r_out_tag;

endmodule

// File: tb/tb_csa_tree_mult_pipe.sv
module tb_csa_tree_mult_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst32, flush32, rst8, flush8;

  csa_tree_mult_pipe_if #(.WIDTH(32), .TAG_W(6)) b32 ();
  csa_tree_mult_pipe_if #(.WIDTH(8),  .TAG_W(6)) b8 ();

  csa_tree_mult_pipe #(.WIDTH(32), .TAG_W(6)) u_dut32 (
    .clk(clk), .reset(rst32), .flush(flush32), .bus(b32.slave));
  csa_tree_mult_pipe #(.WIDTH(8), .TAG_W(6)) u_dut8 (
    .clk(clk), .reset(rst8), .flush(flush8), .bus(b8.slave));

  typedef struct {
    logic [63:0] prod;
    logic [5:0]  tag;
  } exp_t;

  exp_t q32[$];
  exp_t q8[$];
  int checks   = 0;
  int failures = 0;
  logic [63:0] cur_exp32;
  logic [15:0] cur_exp8;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: plain integer multiply of the extended operands, reduced mod 2^(2W).
  function automatic logic [63:0] ref32(input logic [31:0] a, input logic [31:0] b, input logic s);
    longint ea, eb;
    ea = s ? longint'($signed(a)) : longint'({32'h0, a});
    eb = s ? longint'($signed(b)) : longint'({32'h0, b});
    return 64'(ea * eb);
  endfunction

  function automatic logic [15:0] ref8(input logic [7:0] a, input logic [7:0] b, input logic s);
    int ea, eb;
    ea = s ? int'($signed(a)) : int'({24'h0, a});
    eb = s ? int'($signed(b)) : int'({24'h0, b});
    return 16'(ea * eb);
  endfunction

  // Monitors: pop and compare whenever a result is consumed; flush/reset empty the scoreboard.
  always @(negedge clk) begin
    if (!rst32 && b32.out_valid === 1'b1 && b32.out_ready === 1'b1) begin
      if (q32.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL m32_unexpected: got tag %0d product 0x%0h, required no output", b32.out_tag, b32.out_product);
      end else begin
        exp_t e;
        e = q32.pop_front();
        chk("m32_product", b32.out_product, e.prod);
        chk("m32_tag", 64'(b32.out_tag), 64'(e.tag));
      end
    end
    if (rst32 || flush32) q32.delete();
  end

  always @(negedge clk) begin
    if (!rst8 && b8.out_valid === 1'b1 && b8.out_ready === 1'b1) begin
      if (q8.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL m8_unexpected: got tag %0d product 0x%0h, required no output", b8.out_tag, b8.out_product);
      end else begin
        exp_t e;
        e = q8.pop_front();
        chk("m8_product", 64'(b8.out_product), e.prod);
        chk("m8_tag", 64'(b8.out_tag), 64'(e.tag));
      end
    end
    if (rst8 || flush8) q8.delete();
  end

  // ---------------- 32-bit driver helpers ----------------
  task automatic step32();
    @(negedge clk);
    if (b32.in_valid && b32.in_ready === 1'b1 && !flush32 && !rst32)
      q32.push_back('{prod: cur_exp32, tag: b32.in_tag});
    @(posedge clk);
    #1;
  endtask

  task automatic drive32(input logic [31:0] a, input logic [31:0] b, input logic s,
                         input logic [5:0] t, input logic [63:0] e);
    b32.in_valid = 1'b1; b32.in_a = a; b32.in_b = b; b32.in_signed = s; b32.in_tag = t;
    cur_exp32 = e;
  endtask

  task automatic drive32_rand(input logic [5:0] t);
    logic [31:0] a, b;
    logic s;
    a = $urandom; b = $urandom; s = 1'($urandom_range(0, 1));
    drive32(a, b, s, t, ref32(a, b, s));
  endtask

  task automatic idle32();
    b32.in_valid = 1'b0; b32.in_a = $urandom; b32.in_b = $urandom; b32.in_tag = 6'($urandom);
  endtask

  task automatic drain32(input string name);
    int n;
    n = 0;
    idle32();
    b32.out_ready = 1'b1;
    while (q32.size() != 0 && n < 60) begin step32(); n++; end
    repeat (6) step32();
    chk(name, 64'(q32.size()), 64'd0);
  endtask

  // ---------------- 8-bit driver helpers ----------------
  task automatic step8(output bit acc);
    @(negedge clk);
    acc = (b8.in_valid && b8.in_ready === 1'b1 && !flush8 && !rst8);
    if (acc) q8.push_back('{prod: 64'(cur_exp8), tag: b8.in_tag});
    @(posedge clk);
    #1;
  endtask

  task automatic seq32();
    int cnt, first, last, seen;
    logic [63:0] p;
    logic [5:0]  t;
    rst32 = 1'b1; flush32 = 1'b0; b32.out_ready = 1'b1; b32.in_signed = 1'b0; cur_exp32 = '0;
    idle32();
    repeat (3) step32();
    chk("rst_out_valid", 64'(b32.out_valid), 64'd0);
    chk("rst_out_product", b32.out_product, 64'd0);
    chk("rst_out_tag", 64'(b32.out_tag), 64'd0);
    chk("rst_in_ready", 64'(b32.in_ready), 64'd1);
    rst32 = 1'b0;
    repeat (2) step32();

    // Latency of the unsigned all-ones boundary case.
    drive32(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 6'd5, 64'hFFFF_FFFE_0000_0001);
    step32();
    idle32();
    seen = 0;
    for (int k = 1; k <= 3; k++) begin
      if (b32.out_valid !== 1'b0) seen++;
      step32();
    end
    chk("lat_early_valid", 64'(seen), 64'd0);
    chk("lat_valid", 64'(b32.out_valid), 64'd1);
    chk("lat_product", b32.out_product, 64'hFFFF_FFFE_0000_0001);
    chk("lat_tag", 64'(b32.out_tag), 64'd5);
    step32();

    // Signed/unsigned boundaries, back to back.
    drive32(32'h8000_0000, 32'h8000_0000, 1'b1, 6'd1, 64'h4000_0000_0000_0000); step32();
    drive32(32'hFFFF_FFFF, 32'h0000_0002, 1'b1, 6'd2, 64'hFFFF_FFFF_FFFF_FFFE); step32();
    drive32(32'hFFFF_FFFF, 32'h0000_0002, 1'b0, 6'd3, 64'h0000_0001_FFFF_FFFE); step32();
    drive32(32'h7FFF_FFFF, 32'h8000_0000, 1'b1, 6'd4, 64'hC000_0000_8000_0000); step32();
    drain32("directed_drained");

    // Eight back-to-back random ops with out_ready held high.
    cnt = 0; first = -1; last = -1;
    for (int k = 0; k < 20; k++) begin
      if (k < 8) drive32_rand(6'(10 + k)); else idle32();
      if (b32.out_valid === 1'b1) begin
        cnt++;
        if (first < 0) first = k;
        last = k;
      end
      step32();
    end
    chk("stream_count", 64'(cnt), 64'd8);
    chk("stream_first_cycle", 64'(first), 64'd4);
    chk("stream_contiguous", 64'(last - first + 1), 64'd8);
    drain32("stream_drained");

    // Stall at the first result with in_valid held high.
    seen = 0;
    for (int k = 0; k < 10 && seen == 0; k++) begin
      drive32_rand(6'(20 + k));
      if (b32.out_valid === 1'b1) seen = 1; else step32();
    end
    chk("stall_result_seen", 64'(seen), 64'd1);
    b32.out_ready = 1'b0;
    #1;
    chk("stall_in_ready", 64'(b32.in_ready), 64'd0);
    p = b32.out_product; t = b32.out_tag;
    for (int k = 0; k < 3; k++) begin
      step32();
      chk("stall_product_stable", b32.out_product, p);
      chk("stall_tag_stable", 64'(b32.out_tag), 64'(t));
      chk("stall_valid_held", 64'(b32.out_valid), 64'd1);
    end
    drain32("stall_drained");

    // Flush with three ops in flight, oldest stalled at the output.
    drive32_rand(6'd40); step32();
    drive32_rand(6'd41); step32();
    drive32_rand(6'd42); step32();
    idle32(); step32();
    chk("flush_pre_valid", 64'(b32.out_valid), 64'd1);
    b32.out_ready = 1'b0; flush32 = 1'b1; drive32_rand(6'd43);
    step32();
    flush32 = 1'b0; b32.out_ready = 1'b1;
    chk("flush_out_valid", 64'(b32.out_valid), 64'd0);
    drive32_rand(6'd44); step32();
    idle32();
    seen = 0;
    for (int k = 1; k <= 3; k++) begin
      if (b32.out_valid !== 1'b0) seen++;
      step32();
    end
    chk("post_flush_early", 64'(seen), 64'd0);
    chk("post_flush_valid", 64'(b32.out_valid), 64'd1);
    chk("post_flush_tag", 64'(b32.out_tag), 64'd44);
    drain32("flush_drained");

    // Flush while not stalled: the op presented alongside it is dropped.
    drive32_rand(6'd45); flush32 = 1'b1; step32();
    flush32 = 1'b0; idle32();
    seen = 0;
    for (int k = 0; k < 6; k++) begin
      if (b32.out_valid !== 1'b0) seen++;
      step32();
    end
    chk("flush_discards_input", 64'(seen), 64'd0);

    // Reset mid-stream.
    for (int k = 0; k < 6; k++) begin drive32_rand(6'(50 + k)); step32(); end
    rst32 = 1'b1; drive32_rand(6'd56); step32();
    rst32 = 1'b0; idle32();
    chk("midrst_out_valid", 64'(b32.out_valid), 64'd0);
    chk("midrst_out_product", b32.out_product, 64'd0);
    chk("midrst_out_tag", 64'(b32.out_tag), 64'd0);
    chk("midrst_in_ready", 64'(b32.in_ready), 64'd1);
    drive32(32'd7, 32'd6, 1'b0, 6'd60, 64'h2A); step32();
    drain32("midrst_drained");

    // Random traffic with random backpressure and occasional flush.
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 3) != 0) drive32_rand(6'($urandom)); else idle32();
      b32.out_ready = ($urandom_range(0, 3) != 0);
      flush32 = ($urandom_range(0, 63) == 0);
      step32();
    end
    flush32 = 1'b0;
    drain32("random32_drained");
  endtask

  task automatic seq8();
    int ops, guard;
    bit acc;
    logic [7:0] a, b;
    logic s;
    rst8 = 1'b1; flush8 = 1'b0; b8.out_ready = 1'b1; b8.in_valid = 1'b0;
    b8.in_a = '0; b8.in_b = '0; b8.in_signed = 1'b0; b8.in_tag = '0; cur_exp8 = '0;
    repeat (3) step8(acc);
    rst8 = 1'b0;

    b8.in_valid = 1'b1; b8.in_a = 8'h80; b8.in_b = 8'h80; b8.in_signed = 1'b1; b8.in_tag = 6'd1;
    cur_exp8 = 16'h4000; step8(acc);
    b8.in_a = 8'hFF; b8.in_b = 8'hFF; b8.in_signed = 1'b0; b8.in_tag = 6'd2;
    cur_exp8 = 16'hFE01; step8(acc);

    ops = 0; guard = 0;
    while (ops < 10000 && guard < 40000) begin
      a = 8'($urandom); b = 8'($urandom); s = 1'($urandom_range(0, 1));
      b8.in_valid = 1'b1; b8.in_a = a; b8.in_b = b; b8.in_signed = s; b8.in_tag = 6'($urandom);
      cur_exp8 = ref8(a, b, s);
      b8.out_ready = ($urandom_range(0, 4) != 0);
      step8(acc);
      if (acc) ops++;
      guard++;
    end
    chk("sweep8_ops_issued", 64'(ops), 64'd10000);
    b8.in_valid = 1'b0; b8.out_ready = 1'b1;
    guard = 0;
    while (q8.size() != 0 && guard < 60) begin step8(acc); guard++; end
    repeat (6) step8(acc);
    chk("sweep8_drained", 64'(q8.size()), 64'd0);
  endtask

  initial begin
    #(10 * 80000);
    $display("FAIL watchdog: simulation exceeded its cycle budget");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1);
  end

  initial begin
    fork
      seq32();
      seq8();
    join
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
